// File: rtl/spi_ctrl_pkg.sv
// Shared definitions for the SPI frame controller: FSM state encoding,
// command-byte layout and byte width.
package spi_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CMD     = 2'd1,
        ST_DATA    = 2'd2,
        ST_DISCARD = 2'd3
    } ctrl_state_t;

    // Bit of the command byte that selects write (1) or read (0).
    localparam int CMD_WR_BIT = 7;

    // Width of one SPI byte.
    localparam int BYTE_W = 8;

endpackage

// File: rtl/spi_frame_ctrl_sync.sv
// Multi-stage synchronizer for one raw SPI pin, with a registered copy of the
// synchronized value so the parent can detect edges without another flop.
module spi_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_VAL   = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    output logic sync,
    output logic sync_prev
);

    logic [SYNC_STAGES-1:0] stages;

    // Shift the pin through the synchronizer chain and keep the last synchronized value.
    always_ff @(posedge clk) begin
        if (rst) begin
            stages    <= {SYNC_STAGES{RESET_VAL}};
            sync_prev <= RESET_VAL;
        end else begin
            stages    <= {stages[SYNC_STAGES-2:0], pin};
            sync_prev <= stages[SYNC_STAGES-1];
        end
    end

    assign sync = stages[SYNC_STAGES-1];

endmodule

// File: rtl/spi_frame_ctrl.sv
// Frame-level SPI controller: synchronizes the SPI pins, drives the byte
// deserializer (shift strobe, realignment reset) and turns each write frame
// into register-file write strobes.
// Optional burst mode: define SPI_CTRL_AUTOINC_EN to keep writing with an
// auto-incrementing address; otherwise only one data byte per frame is legal.
module spi_frame_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi,
    output logic              pkt_din,
    output logic              pkt_en,
    output logic              pkt_rst,
    input  logic [BYTE_W-1:0] pkt_byte,
    input  logic              pkt_byte_flg,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [BYTE_W-1:0] wr_data,
    output logic              frame_err,
    output logic              busy
);

    logic sclk_sync, sclk_prev;
    logic cs_n_sync, cs_n_prev;
    logic mosi_sync, unused_mosi_prev;

    logic sclk_rise, cs_rise, byte_rise;
    logic flg_prev;
    logic [2:0] bit_cnt;

    ctrl_state_t state, next_state;
    logic [ADDR_W-1:0] addr, next_addr;
    logic ovf_pend, next_ovf;
    logic wr_en_d, err_d;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_sclk (
        .clk       (clk),
        .rst       (rst),
        .pin       (spi_sclk),
        .sync      (sclk_sync),
        .sync_prev (sclk_prev)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
        .clk       (clk),
        .rst       (rst),
        .pin       (spi_cs_n),
        .sync      (cs_n_sync),
        .sync_prev (cs_n_prev)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk       (clk),
        .rst       (rst),
        .pin       (spi_mosi),
        .sync      (mosi_sync),
        .sync_prev (unused_mosi_prev)
    );

    assign sclk_rise = sclk_sync & ~sclk_prev;
    assign cs_rise   = cs_n_sync & ~cs_n_prev;
    assign byte_rise = pkt_byte_flg & ~flg_prev;
    assign pkt_din   = mosi_sync;
    assign pkt_rst   = rst | cs_n_sync;

    // Shift strobe, bit position within the current byte, flag history and frame-active indication.
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_en   <= 1'b0;
            bit_cnt  <= 3'd0;
            flg_prev <= 1'b0;
            busy     <= 1'b0;
        end else begin
            pkt_en   <= sclk_rise & ~cs_n_sync;
            flg_prev <= pkt_byte_flg;
            busy     <= ~cs_n_sync;
            if (cs_n_sync) begin
                bit_cnt <= 3'd0;
            end else if (sclk_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // FSM state, latched address and registered write/error outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            ovf_pend  <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            frame_err <= 1'b0;
        end else begin
            state     <= next_state;
            addr      <= next_addr;
            ovf_pend  <= next_ovf;
            wr_en     <= wr_en_d;
            frame_err <= err_d;
            if (wr_en_d) begin
                wr_addr <= addr;
                wr_data <= pkt_byte;
            end
        end
    end

    // Frame decode: command byte, data writes, discard handling, then chip-select release overrides.
    always_comb begin
        next_state = state;
        next_addr  = addr;
        next_ovf   = ovf_pend;
        wr_en_d    = 1'b0;
        err_d      = 1'b0;

        case (state)
            ST_IDLE: begin
                next_ovf = 1'b0;
                if (!cs_n_sync) begin
                    next_state = ST_CMD;
                end
            end
            ST_CMD: begin
                if (byte_rise) begin
                    if (pkt_byte[CMD_WR_BIT]) begin
                        next_addr  = pkt_byte[ADDR_W-1:0];
                        next_state = ST_DATA;
                    end else begin
                        next_state = ST_DISCARD;
                    end
                end
            end
            ST_DATA: begin
                if (byte_rise) begin
                    wr_en_d = 1'b1;
`ifdef SPI_CTRL_AUTOINC_EN
                    next_addr = addr + ADDR_W'(1);
`else
                    next_state = ST_DISCARD;
                    next_ovf   = 1'b1;
`endif
                end
            end
            ST_DISCARD: begin
                if (byte_rise && ovf_pend) begin
                    err_d    = 1'b1;
                    next_ovf = 1'b0;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase

        // A byte finishing in the same cycle has already been handled above.
        if (cs_rise) begin
            next_state = ST_IDLE;
            next_ovf   = 1'b0;
            if ((bit_cnt != 3'd0) && (state != ST_DISCARD)) begin
                err_d = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_spi_frame_ctrl.sv
// Self-checking bench for spi_frame_ctrl with a behavioural byte deserializer
// and a scoreboard of expected register writes.
// Build with SPI_CTRL_AUTOINC_EN defined to check burst mode.
module tb_spi_frame_ctrl;
    import spi_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       spi_sclk, spi_cs_n, spi_mosi;
    logic       pkt_din, pkt_en, pkt_rst;
    logic [7:0] pkt_byte;
    logic       pkt_byte_flg;
    logic       wr_en;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_err, busy;

    typedef struct {
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  err_seen = 0;
    int  en_seen = 0;
    int  bits_sent = 0;
    logic [2:0] model_cnt;

    spi_frame_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .spi_sclk     (spi_sclk),
        .spi_cs_n     (spi_cs_n),
        .spi_mosi     (spi_mosi),
        .pkt_din      (pkt_din),
        .pkt_en       (pkt_en),
        .pkt_rst      (pkt_rst),
        .pkt_byte     (pkt_byte),
        .pkt_byte_flg (pkt_byte_flg),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .frame_err    (frame_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Behavioural MSB-first deserializer; the flag is a level updated on each shift.
    always @(posedge clk) begin
        if (pkt_rst) begin
            model_cnt    <= 3'd0;
            pkt_byte     <= 8'h00;
            pkt_byte_flg <= 1'b0;
        end else if (pkt_en) begin
            model_cnt    <= model_cnt + 3'd1;
            pkt_byte     <= {pkt_byte[6:0], pkt_din};
            pkt_byte_flg <= (model_cnt == 3'd7);
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Scoreboard side: compare every write strobe against the queue, count error and shift pulses.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            check_output("wr_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                wr_t e;
                e = exp_q.pop_front();
                check_output("wr_addr", 32'(wr_addr), 32'(e.addr));
                check_output("wr_data", 32'(wr_data), 32'(e.data));
            end
        end
        if (frame_err === 1'b1) err_seen++;
        if (pkt_en === 1'b1) en_seen++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic apply_stimulus(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            spi_mosi = b[i];
            wait_clk(4);
            spi_sclk = 1'b1;
            bits_sent++;
            wait_clk(4);
            spi_sclk = 1'b0;
        end
    endtask

    task automatic start_frame();
        spi_cs_n = 1'b0;
        wait_clk(4);
    endtask

    task automatic end_checks(input string tag, input int exp_err);
        check_output({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
        check_output({tag, "_frame_err_count"}, 32'(err_seen), 32'(exp_err));
        check_output({tag, "_pkt_en_count"}, 32'(en_seen), 32'(bits_sent));
        check_output({tag, "_busy_idle"}, 32'(busy), 32'd0);
        check_output({tag, "_pkt_rst_idle"}, 32'(pkt_rst), 32'd1);
        err_seen  = 0;
        en_seen   = 0;
        bits_sent = 0;
        exp_q.delete();
    endtask

    task automatic end_frame(input string tag, input int exp_err);
        wait_clk(4);
        spi_cs_n = 1'b1;
        wait_clk(12);
        end_checks(tag, exp_err);
    endtask

    task automatic push_wr(input logic [6:0] a, input logic [7:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        rst      = 1'b1;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        wait_clk(3);

        $display("[TB] reset state");
        check_output("rst_pkt_en", 32'(pkt_en), 32'd0);
        check_output("rst_pkt_rst", 32'(pkt_rst), 32'd1);
        check_output("rst_wr_en", 32'(wr_en), 32'd0);
        check_output("rst_wr_addr", 32'(wr_addr), 32'd0);
        check_output("rst_wr_data", 32'(wr_data), 32'd0);
        check_output("rst_frame_err", 32'(frame_err), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        wait_clk(5);
        err_seen = 0;
        en_seen  = 0;

        $display("[TB] single write 0x85 0x3C");
        push_wr(7'h05, 8'h3C);
        start_frame();
        apply_stimulus(8'h85, 8);
        apply_stimulus(8'h3C, 8);
        end_frame("write1", 0);

        $display("[TB] read command 0x05 0xAA");
        start_frame();
        apply_stimulus(8'h05, 8);
        check_output("read_busy_active", 32'(busy), 32'd1);
        apply_stimulus(8'hAA, 8);
        end_frame("read", 0);

        $display("[TB] frame 0xFF 0x11 0x22");
        push_wr(7'h7F, 8'h11);
`ifdef SPI_CTRL_AUTOINC_EN
        push_wr(7'h00, 8'h22);
`endif
        start_frame();
        apply_stimulus(8'hFF, 8);
        apply_stimulus(8'h11, 8);
        apply_stimulus(8'h22, 8);
`ifdef SPI_CTRL_AUTOINC_EN
        end_frame("burst", 0);
`else
        end_frame("burst", 1);
`endif

        $display("[TB] partial byte then realignment");
        start_frame();
        apply_stimulus(8'h81, 8);
        apply_stimulus(8'h00, 5);
        end_frame("partial", 1);
        push_wr(7'h02, 8'h55);
        start_frame();
        apply_stimulus(8'h82, 8);
        apply_stimulus(8'h55, 8);
        end_frame("realign", 0);

        $display("[TB] chip select release in same cycle as flag rise");
        push_wr(7'h03, 8'h99);
        start_frame();
        apply_stimulus(8'h83, 8);
        apply_stimulus(8'h99, 7);
        spi_mosi = 1'b1;
        wait_clk(4);
        spi_sclk = 1'b1;
        bits_sent++;
        wait_clk(2);
        spi_cs_n = 1'b1;
        wait_clk(2);
        spi_sclk = 1'b0;
        wait_clk(12);
        check_output("race_state_idle", 32'(dut.state), 32'(ST_IDLE));
        end_checks("race", 0);

        $display("[TB] reset mid data byte");
        start_frame();
        apply_stimulus(8'h84, 8);
        apply_stimulus(8'hA0, 3);
        wait_clk(1);
        rst = 1'b1;
        wait_clk(1);
        check_output("midrst_pkt_en", 32'(pkt_en), 32'd0);
        check_output("midrst_pkt_rst", 32'(pkt_rst), 32'd1);
        check_output("midrst_wr_en", 32'(wr_en), 32'd0);
        check_output("midrst_wr_addr", 32'(wr_addr), 32'd0);
        check_output("midrst_wr_data", 32'(wr_data), 32'd0);
        check_output("midrst_frame_err", 32'(frame_err), 32'd0);
        check_output("midrst_busy", 32'(busy), 32'd0);
        rst      = 1'b0;
        spi_cs_n = 1'b1;
        wait_clk(12);
        check_output("midrst_no_err", 32'(err_seen), 32'd0);
        err_seen  = 0;
        en_seen   = 0;
        bits_sent = 0;
        push_wr(7'h06, 8'h42);
        start_frame();
        apply_stimulus(8'h86, 8);
        apply_stimulus(8'h42, 8);
        end_frame("postrst", 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_frame_ctrl.md
# spi_frame_ctrl

Frame-level controller that sequences the SPI byte deserializer (`SPI_pkt`) and turns received SPI frames into register-file write strobes. It synchronizes the raw SPI pins into the `clk` domain and generates the deserializer's shift enable and realignment reset. It decodes the first byte of each chip-select frame as a command/address and issues one write per following data byte. It sits between the chip pads and the configuration register bank.

## Interface
- `ADDR_W`, default 7: register address width; legal range 1..7.
- `SYNC_STAGES`, default 2: flip-flop stages on each SPI pin synchronizer; minimum 2.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `spi_sclk`  in  1  raw SPI clock pin (mode 0: sample on rising edge).
- `spi_cs_n`  in  1  raw chip select pin, active low.
- `spi_mosi`  in  1  raw MOSI pin.
- `pkt_din`  out  1  MOSI after synchronization; drives deserializer `din`.
- `pkt_en`  out  1  one-cycle shift strobe to deserializer `en`.
- `pkt_rst`  out  1  deserializer reset; realigns its bit counter between frames.
- `pkt_byte`  in  8  deserializer `dout`.
- `pkt_byte_flg`  in  1  deserializer `byte_flg`.
- `wr_en`  out  1  one-cycle register write strobe.
- `wr_addr`  out  ADDR_W  write address, valid with `wr_en`.
- `wr_data`  out  8  write data, valid with `wr_en`.
- `frame_err`  out  1  one-cycle pulse on a malformed frame.
- `busy`  out  1  high while a frame is in progress (`cs` active).

## Operation
- `spi_sclk`, `spi_cs_n` and `spi_mosi` each pass through `SYNC_STAGES` flops. `pkt_din` is the synchronized MOSI, so it stays aligned with the synchronized `sclk`.
- A `sclk` rising edge is the synchronized `sclk` high while its previous value was low. When the synchronized `cs_n` is low on that edge, `pkt_en` pulses for 1 cycle and an internal 3-bit bit counter increments, wrapping at 8.
- `pkt_rst = rst | cs_n_sync`. The deserializer is therefore held in reset between frames and every frame starts byte-aligned.
- `pkt_byte_flg` is a level. It rises after the 8th shift and stays high until the next shift. A byte is accepted on its rising edge (flag high, registered previous flag low).
- FSM states:
  - IDLE: `cs_n_sync` high. Go to CMD when `cs_n_sync` is low.
  - CMD: on the first byte, if `byte[7]=1` (write), latch `addr = byte[ADDR_W-1:0]` and go to DATA. If `byte[7]=0` (read, unsupported), go to DISCARD with no error.
  - DATA: on each byte, pulse `wr_en` with the current `addr` and the byte value, then apply the configuration rule below.
  - DISCARD: ignore all bytes until `cs_n_sync` goes high.
- In every state, `cs_n_sync` going high returns the FSM to IDLE. If the bit counter is nonzero at that point (partial byte), `frame_err` pulses, unless the FSM was in DISCARD.
- A frame containing only a command byte produces no write and no error.
- If the flag rising edge and `cs` deassertion are detected in the same cycle, the byte is processed first (write or error as applicable) and the FSM then goes to IDLE.
- Reset: state IDLE, bit counter 0, `pkt_en=0`, `pkt_rst=1`, `wr_en=0`, `wr_addr=0`, `wr_data=0`, `frame_err=0`, `busy=0`, all synchronizer flops 1 except MOSI (0).

## Timing
- A pin edge reaches the synchronized signal after `SYNC_STAGES` cycles. `pkt_en` is asserted in the following cycle (latency `SYNC_STAGES+1` from the pin).
- `pkt_byte_flg` rises 1 cycle after the 8th `pkt_en`. `wr_en`, `wr_addr` and `wr_data` are registered and asserted 1 cycle after the flag rising edge.
- `busy` equals `~cs_n_sync` delayed 1 cycle. `frame_err` is asserted 1 cycle after `cs` deassertion is detected.
- Requirement on the SPI master: `sclk` high and low phases are each ≥ 3 `clk` periods, and `cs_n` setup/hold to `sclk` is ≥ 3 `clk` periods.

## Configuration
- `SPI_CTRL_AUTOINC_EN` defined (burst mode):
  - DATA stays in DATA after each write.
  - `addr` increments by 1 modulo 2^ADDR_W (wraps to 0) after each write.
  - Frame length is unlimited.
- `SPI_CTRL_AUTOINC_EN` not defined:
  - After the first data write, the FSM goes to DISCARD.
  - Any further complete byte in that frame pulses `frame_err` once and writes nothing.

## Structure
- Shared package `spi_ctrl_pkg`:
  - FSM state encodings: IDLE=0, CMD=1, DATA=2, DISCARD=3.
  - `CMD_WR_BIT=7`.
  - `BYTE_W=8`.
- One sub-module, `spi_sync_edge`: a parameterized `SYNC_STAGES` synchronizer for one pin, with a registered previous-value output for edge detection. It is instantiated three times.

## Test plan
- Frame `cs` low, bytes 0x85, 0x3C, `cs` high → one `wr_en` with `wr_addr=0x05`, `wr_data=0x3C`; `frame_err` stays 0.
- Frame with bytes 0x05, 0xAA (read command) → no `wr_en`, no `frame_err`, `busy` high only during the frame.
- Frame with bytes 0xFF, 0x11, 0x22:
  - With `SPI_CTRL_AUTOINC_EN` → writes (0x7F,0x11) then (0x00,0x22), showing address wrap.
  - Without it → write (0x7F,0x11) plus one `frame_err` pulse.
- Frame with 0x81 followed by 5 `sclk` edges, then `cs` high → no write; `frame_err` pulses once; next frame 0x82, 0x55 writes (0x02,0x55), proving realignment.
- Assert `rst` for 1 cycle mid-data-byte → all outputs return to reset values next cycle, `pkt_rst=1`; a subsequent clean frame writes correctly.
- `cs` deassert detected in the same cycle as the flag rise on the data byte (0x83, 0x99) → write (0x03,0x99) occurs, no `frame_err`, FSM in IDLE.
